card_regfile_arbiter: RTL
=========================

Name: card_regfile_arbiter

Overview:
- Shares the single-write/single-read card regfile between four requesters:
  - colour-init writer (compute_colors stream)
  - game-state writer (state_machine card updates)
  - display sweep reader (reads all cards for cardsCtl)
  - click-test single reader (card press checker)
- Sits between the requesters and the regfile. Replaces ad-hoc muxing with explicit req/gnt handshakes, an uninterruptible sweep FSM and write-to-read forwarding.

Parameters:
- ADDR_W, 6, card address width.
- DATA_W, 8, card data width (colour + state).
- MAX_CARDS, 36, upper clamp for sweep length.

Ports:
- clk  in  1  pixel clock (65 MHz domain)
- rst  in  1  synchronous, active-low reset (rst=0 resets on rising clk)
- wi_req  in  1  colour-init write request
- wi_addr  in  ADDR_W  colour-init write address
- wi_data  in  DATA_W  colour-init write data
- wi_gnt  out  1  colour-init write performed this cycle
- ws_req  in  1  game-state write request
- ws_addr  in  ADDR_W  game-state write address
- ws_data  in  DATA_W  game-state write data
- ws_gnt  out  1  game-state write performed this cycle
- sweep_start  in  1  pulse: begin reading cards 0..sweep_count-1
- sweep_count  in  ADDR_W  number of cards to sweep
- sweep_valid  out  1  sweep_data/sweep_index valid
- sweep_index  out  ADDR_W  card index of sweep_data
- sweep_data  out  DATA_W  card data
- sweep_done  out  1  one-cycle pulse after the last sweep beat
- sweep_overrun  out  1  one-cycle pulse: sweep_start ignored (already busy)
- rd_req  in  1  single-read request
- rd_addr  in  ADDR_W  single-read address
- rd_gnt  out  1  single read issued this cycle
- rd_valid  out  1  rd_data valid (cycle after rd_gnt)
- rd_data  out  DATA_W  single-read result
- rf_w_en  out  1  regfile write enable
- rf_w_addr  out  ADDR_W  regfile write address
- rf_w_data  out  DATA_W  regfile write data
- rf_r_addr  out  ADDR_W  regfile read address
- rf_r_data  in  DATA_W  regfile read data (valid one cycle after rf_r_addr)

Behaviour:
- Reset (rst=0):
  - All gnt/valid/done/overrun outputs, rf_w_en, addresses and data outputs are 0.
  - FSM goes to IDLE.
  - Write round-robin pointer favours ws.
- Write arbitration (combinational grant, registered regfile drive):
  - Requester holds req, addr and data stable until it sees gnt. gnt is asserted in the cycle the request is accepted.
  - rf_w_en/addr/data are registered one cycle after gnt.
  - Only one requester: it is granted.
  - Both requesting: the pointer side is granted, then the pointer flips. Back-to-back contention alternates ws, wi, ws, wi.
  - Writes are never blocked by reads.
- Read FSM states: IDLE, SWEEP, DRAIN.
  - IDLE + sweep_start: latch len = min(sweep_count, MAX_CARDS).
    - len=0: pulse sweep_done the next cycle and stay IDLE.
    - Otherwise: go to SWEEP with idx=0.
  - IDLE + rd_req with no sweep_start: rd_gnt=1, rf_r_addr<=rd_addr, rd_valid=1 the next cycle. sweep_start beats rd_req in the same cycle, so rd waits.
  - SWEEP: issue rf_r_addr=idx each cycle, idx increments.
    - sweep_valid/sweep_index follow one cycle later, once per address, contiguously.
    - After issuing len-1, go to DRAIN.
  - DRAIN: the last beat is presented. sweep_done pulses the following cycle, then return to IDLE.
  - rd_req is not granted in SWEEP or DRAIN.
  - sweep_start in SWEEP or DRAIN: ignored, sweep_overrun pulses one cycle.
- Forwarding: if a granted write address equals the read address issued in the same cycle, the returned data (sweep_data or rd_data) equals the write data, not the stale rf_r_data.
- Outputs hold their last value when not valid. Consumers qualify with the valid signals.
- Reset mid-sweep: abort immediately. No sweep_done pulse, no further sweep_valid.
- Latency:
  - Single read: rd_gnt to rd_valid is 1 cycle.
  - Sweep of N cards: first sweep_valid 2 cycles after sweep_start; sweep_done N+2 cycles after sweep_start.

Test Plan:
- Reset, then ws_req=1 with addr=5, data=0x3C. Expect ws_gnt in the same cycle, then rf_w_en=1, rf_w_addr=5, rf_w_data=0x3C next cycle. All other outputs 0.
- wi_req and ws_req held for 4 cycles. Expect grants ws, wi, ws, wi and 4 regfile writes in that order.
- sweep_start with sweep_count=16, regfile preloaded data=addr. Expect sweep_valid for 16 contiguous cycles, index/data 0..15, then sweep_done at cycle 18.
- rd_req at addr 7 during a sweep. Expect rd_gnt only in the cycle after the FSM is back in IDLE, rd_valid with data 7 one cycle later. A second sweep_start mid-sweep gives a sweep_overrun pulse and does not disturb sequence 0..15.
- sweep_count=0 gives a sweep_done pulse with no valids. sweep_count=50 gives 36 beats. ws write to addr 3 with data 0xAA in the cycle sweep issues addr 3 gives sweep_data 0xAA at index 3.
- rst=0 asserted at sweep beat 5 of 16. Expect all outputs 0 next cycle, no done pulse. A fresh sweep then runs normally.

Source files
------------

// File: rtl/card_regfile_arbiter.sv
// Arbitrates the shared card regfile: round-robin write port, sweep/single-read
// read port, and write-to-read forwarding on the returned data.
//   state   | meaning
//   S_IDLE  | accepts sweep_start or single reads
//   S_SWEEP | issuing sweep addresses 0..len-1, one per cycle
//   S_DRAIN | last sweep beat on the outputs; sweep_done next
module card_regfile_arbiter #(
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 8,
  parameter int MAX_CARDS = 36
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wi_req,
  input  logic [ADDR_W-1:0] wi_addr,
  input  logic [DATA_W-1:0] wi_data,
  output logic              wi_gnt,
  input  logic              ws_req,
  input  logic [ADDR_W-1:0] ws_addr,
  input  logic [DATA_W-1:0] ws_data,
  output logic              ws_gnt,
  input  logic              sweep_start,
  input  logic [ADDR_W-1:0] sweep_count,
  output logic              sweep_valid,
  output logic [ADDR_W-1:0] sweep_index,
  output logic [DATA_W-1:0] sweep_data,
  output logic              sweep_done,
  output logic              sweep_overrun,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rf_w_en,
  output logic [ADDR_W-1:0] rf_w_addr,
  output logic [DATA_W-1:0] rf_w_data,
  output logic [ADDR_W-1:0] rf_r_addr,
  input  logic [DATA_W-1:0] rf_r_data
);

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN} state_t;

  localparam logic [ADDR_W-1:0] MAX_LEN = ADDR_W'(MAX_CARDS);

  state_t            state;
  logic              ws_ptr;
  logic [ADDR_W-1:0] len;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] clamp_len;
  logic [DATA_W-1:0] ret_data;
  logic [DATA_W-1:0] sweep_data_q;
  logic [DATA_W-1:0] rd_data_q;

  assign ws_gnt = rst & ws_req & (~wi_req | ws_ptr);
  assign wi_gnt = rst & wi_req & (~ws_req | ~ws_ptr);
  assign rd_gnt = rst & (state == S_IDLE) & rd_req & ~sweep_start;

  assign clamp_len = (sweep_count > MAX_LEN) ? MAX_LEN : sweep_count;

  // A write granted in the same cycle as the read lands in the regfile only at
  // the end of the return cycle, so take its data straight from the write port.
  assign ret_data = (rf_w_en && (rf_w_addr == rf_r_addr)) ? rf_w_data : rf_r_data;

  assign sweep_data = sweep_valid ? ret_data : sweep_data_q;
  assign rd_data    = rd_valid    ? ret_data : rd_data_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= S_IDLE;
      ws_ptr        <= 1'b1;
      len           <= '0;
      idx           <= '0;
      rf_w_en       <= 1'b0;
      rf_w_addr     <= '0;
      rf_w_data     <= '0;
      rf_r_addr     <= '0;
      sweep_valid   <= 1'b0;
      sweep_index   <= '0;
      sweep_data_q  <= '0;
      sweep_done    <= 1'b0;
      sweep_overrun <= 1'b0;
      rd_valid      <= 1'b0;
      rd_data_q     <= '0;
    end else begin
      rf_w_en <= wi_gnt | ws_gnt;
      if (ws_gnt) begin
        rf_w_addr <= ws_addr;
        rf_w_data <= ws_data;
      end else if (wi_gnt) begin
        rf_w_addr <= wi_addr;
        rf_w_data <= wi_data;
      end
      if (wi_req && ws_req) ws_ptr <= ~ws_ptr;

      sweep_valid   <= 1'b0;
      sweep_done    <= 1'b0;
      sweep_overrun <= 1'b0;
      rd_valid      <= 1'b0;
      if (sweep_valid) sweep_data_q <= ret_data;
      if (rd_valid)    rd_data_q    <= ret_data;

      case (state)
        S_IDLE: begin
          if (sweep_start) begin
            len <= clamp_len;
            idx <= '0;
            if (clamp_len == '0) sweep_done <= 1'b1;
            else                 state      <= S_SWEEP;
          end else if (rd_req) begin
            rf_r_addr <= rd_addr;
            rd_valid  <= 1'b1;
          end
        end
        S_SWEEP: begin
          rf_r_addr     <= idx;
          sweep_index   <= idx;
          sweep_valid   <= 1'b1;
          idx           <= idx + ADDR_W'(1);
          sweep_overrun <= sweep_start;
          if (idx == len - ADDR_W'(1)) state <= S_DRAIN;
        end
        S_DRAIN: begin
          sweep_done    <= 1'b1;
          sweep_overrun <= sweep_start;
          state         <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
